// File: rtl/wti_pkg.sv
// rtl/wti_pkg.sv - shared constants, mode encoding and helpers for the wavelet-transform output path
package wti_pkg;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        TFORM_L2R = 2'd1,
        TFORM_R2L = 2'd2,
        DONE      = 2'd3
    } wti_mode_e;

    localparam int WTI_DATA_W      = 16;
    localparam int WTI_FRAME_DEPTH = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int frame_len(input int depth);
        return 1 << depth;
    endfunction

    localparam int WTI_FRAME_LEN = frame_len(WTI_FRAME_DEPTH);

endpackage

// File: rtl/wti_fifo_ram.sv
// rtl/wti_fifo_ram.sv - FIFO storage array, synchronous write and combinational read
module wti_fifo_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int AW     = 4
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/wti_out_buffer.sv
// rtl/wti_out_buffer.sv - show-ahead coefficient FIFO with frame marking; optional status via WTI_OUT_STATUS_EN
module wti_out_buffer
    import wti_pkg::*;
#(
    parameter int DATA_W      = WTI_DATA_W,
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_DEPTH = WTI_FRAME_DEPTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_in_valid,
    input  logic [DATA_W-1:0]           i_in_data,
    output logic                        o_fifo_ready,
    output logic                        o_out_valid,
    output logic [DATA_W-1:0]           o_out_data,
    input  logic                        i_out_ready,
    output logic                        o_out_last,
`ifdef WTI_OUT_STATUS_EN
    output logic                        o_overflow,
    output logic [clog2(FIFO_DEPTH):0]  o_level,
    input  logic                        i_ovf_clr,
`endif
    output logic                        o_frame_done
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    // One slot is held back for the word already in flight from transform memory.
    localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 2);
    localparam logic [FRAME_DEPTH-1:0] LAST_IDX = FRAME_DEPTH'(frame_len(FRAME_DEPTH) - 1);

    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [FRAME_DEPTH-1:0] r_frame_cnt;
    logic                   r_frame_done;

    logic w_push;
    logic w_pop;
    logic w_out_valid;
    logic w_out_last;

    assign w_out_valid = (r_count != '0);
    assign w_out_last  = w_out_valid && (r_frame_cnt == LAST_IDX);
    assign w_pop       = w_out_valid && i_out_ready;
    assign w_push      = i_in_valid && ((r_count < FULL_CNT) || w_pop);

    wti_fifo_ram #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_in_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (o_out_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_frame_cnt <= r_frame_cnt + FRAME_DEPTH'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            r_frame_done <= w_pop && w_out_last;
        end
    end

`ifdef WTI_OUT_STATUS_EN
    logic r_overflow;
    logic w_drop;

    assign w_drop = i_in_valid && !w_push;

    // A drop in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_overflow = r_overflow;
    assign o_level    = r_count;
`endif

    assign o_fifo_ready = (r_count <= READY_MAX);
    assign o_out_valid  = w_out_valid;
    assign o_out_last   = w_out_last;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_wti_out_buffer.sv
// tb/tb_wti_out_buffer.sv - self-checking bench for wti_out_buffer (FIFO_DEPTH=16, FRAME_DEPTH=3)
module tb_wti_out_buffer;

    localparam int DW   = 16;
    localparam int FD   = 16;
    localparam int FRD  = 3;
    localparam int FLEN = 1 << FRD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          fifo_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          frame_done;
    logic          ovf_clr = 1'b0;
`ifdef WTI_OUT_STATUS_EN
    logic          overflow;
    logic [4:0]    level;
`endif

    wti_out_buffer #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (FD),
        .FRAME_DEPTH (FRD)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_fifo_ready (fifo_ready),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .i_out_ready  (out_ready),
        .o_out_last   (out_last),
`ifdef WTI_OUT_STATUS_EN
        .o_overflow   (overflow),
        .o_level      (level),
        .i_ovf_clr    (ovf_clr),
`endif
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    int            m_fcnt = 0;
    logic          m_fd   = 1'b0;
    logic          m_ovf  = 1'b0;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          rdy;
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
        logic          er;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        logic mv;
        mv = (q.size() != 0);
        chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
        if (mv) chk("out_data", {16'd0, out_data}, {16'd0, q[0]});
        chk("out_last", {31'd0, out_last}, {31'd0, mv && (m_fcnt == FLEN - 1)});
        chk("fifo_ready", {31'd0, fifo_ready}, {31'd0, q.size() <= FD - 2});
        chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
`ifdef WTI_OUT_STATUS_EN
        chk("level", {27'd0, level}, q.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`endif
    endtask

    // Entered and left at posedge+1; model advances on the edge in between.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
        logic          pop;
        logic          push;
        logic [DW-1:0] dummy;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        ovf_clr   = clr;
        #1;
        model_check();
        pop  = (q.size() != 0) && rdy;
        push = v && ((q.size() < FD) || pop);
        @(posedge clk);
        m_fd = pop && (m_fcnt == FLEN - 1);
        if (pop) begin
            dummy  = q.pop_front();
            m_fcnt = (m_fcnt + 1) % FLEN;
        end
        if (push) q.push_back(d);
        if (v && !push) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        rst_n     = 1'b0;
        q.delete();
        m_fcnt = 0;
        m_fd   = 1'b0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lasts;
        int pop_idx;

        tbl[0] = '{v:1'b1, d:16'hA5A5, rdy:1'b0, ev:1'b0, ed:16'h0000, el:1'b0, er:1'b1};
        tbl[1] = '{v:1'b0, d:16'h0000, rdy:1'b0, ev:1'b1, ed:16'hA5A5, el:1'b0, er:1'b1};
        tbl[2] = '{v:1'b1, d:16'h1234, rdy:1'b1, ev:1'b1, ed:16'hA5A5, el:1'b0, er:1'b1};
        tbl[3] = '{v:1'b0, d:16'h0000, rdy:1'b1, ev:1'b1, ed:16'h1234, el:1'b0, er:1'b1};
        tbl[4] = '{v:1'b0, d:16'h0000, rdy:1'b0, ev:1'b0, ed:16'h0000, el:1'b0, er:1'b1};

        // Reset state
        @(posedge clk);
        do_reset();
        #1;
        chk("rst_fifo_ready", {31'd0, fifo_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
`ifdef WTI_OUT_STATUS_EN
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
`endif
        @(posedge clk);
        #1;

        // Latency-1 show-ahead, table driven
        for (int i = 0; i < 5; i++) begin
            chk("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) chk("tbl_data", {16'd0, out_data}, {16'd0, tbl[i].ed});
            chk("tbl_last", {31'd0, out_last}, {31'd0, tbl[i].el});
            chk("tbl_ready", {31'd0, fifo_ready}, {31'd0, tbl[i].er});
            cycle(tbl[i].v, tbl[i].d, tbl[i].rdy, 1'b0);
        end

        // Fill, overflow, simultaneous push/pop while full
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, DW'(16'h1000 + i), 1'b0, 1'b0);
            if (i == 13) chk("ready_at_14", {31'd0, fifo_ready}, 32'd1);
        end
        chk("ready_at_15", {31'd0, fifo_ready}, 32'd0);
        cycle(1'b1, 16'h100F, 1'b0, 1'b0);
`ifdef WTI_OUT_STATUS_EN
        chk("level_full", {27'd0, level}, 32'd16);
`endif
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("full_head", {16'd0, out_data}, 32'h1000);
`ifdef WTI_OUT_STATUS_EN
        chk("ovf_set", {31'd0, overflow}, 32'd1);
`endif
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle(1'b1, 16'h2000, 1'b1, 1'b0);
        chk("full_pushpop_head", {16'd0, out_data}, 32'h1001);
`ifdef WTI_OUT_STATUS_EN
        chk("full_pushpop_level", {27'd0, level}, 32'd16);
        chk("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
`endif
        cycle(1'b1, 16'hBEEF, 1'b0, 1'b1);
`ifdef WTI_OUT_STATUS_EN
        chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
`endif
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) cycle(1'b0, 16'h0000, (i % 3) != 1, 1'b0);

        // Frame boundaries with continuous streaming
        do_reset();
        lasts = 0;
        for (int i = 0; i < 19; i++) begin
            if (out_last) begin
                chk("frame_last_data", {16'd0, out_data}, 32'(lasts * FLEN + FLEN - 1));
                lasts++;
            end
            cycle(i < 16, DW'(i), 1'b1, 1'b0);
        end
        chk("frame_last_count", lasts, 32'd2);

        // Reset mid-frame: 4 popped, 3 queued
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, DW'(16'h0300 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, fifo_ready}, 32'd1);
        q.delete();
        m_fcnt = 0;
        m_fd   = 1'b0;
        m_ovf  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lasts   = 0;
        pop_idx = 0;
        for (int i = 0; i < 11; i++) begin
            if (out_valid) begin
                pop_idx++;
                if (out_last) begin
                    chk("midrst_last_idx", pop_idx, 32'd8);
                    lasts++;
                end
            end
            cycle(i < 8, DW'(16'h0400 + i), 1'b1, 1'b0);
        end
        chk("midrst_last_count", lasts, 32'd1);
        chk("midrst_pops", pop_idx, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
